// File: rtl/fetch_sched.sv
// rtl/fetch_sched.sv - round-robin instruction fetch scheduler with in-order outstanding queue
module fetch_sched #(
  parameter int N_CNTX   = 8,
  parameter int LEN_WORD = 32,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_CNTX-1:0]   cntx_pending,
  output logic [N_CNTX-1:0]   grant,
  input  logic [LEN_WORD-1:0] grant_pc,
  output logic                grant_taken,
  output logic                mem_req,
  output logic [LEN_WORD-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic                mem_valid,
  input  logic [LEN_WORD-1:0] mem_data,
  input  logic                kill_valid,
  input  logic [N_CNTX-1:0]   kill_mask,
  output logic                out_valid,
  input  logic                out_accept,
  output logic [LEN_WORD-1:0] out_instr,
  output logic [LEN_WORD-1:0] out_pc,
  output logic [N_CNTX-1:0]   out_cntx,
  output logic                proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (N_CNTX > 1) ? $clog2(N_CNTX) : 1;

  logic [CW-1:0]       rr;
  logic [AW:0]         head, tail, fill, count;
  logic [AW-1:0]       hidx, tidx, fidx;
  logic [LEN_WORD-1:0] pc_q    [DEPTH];
  logic [LEN_WORD-1:0] instr_q [DEPTH];
  logic [N_CNTX-1:0]   cntx_q  [DEPTH];
  logic [DEPTH-1:0]    killed_q, filled_q;

  logic [N_CNTX-1:0]   eligible, grant_c;
  logic [CW-1:0]       grant_idx, cand;
  logic                found;
  logic                full, occupied, head_kill, awaiting, fill_ok, pop;

  // Pointers carry one extra wrap bit so full/empty and "no awaiting entry" are unambiguous
  assign hidx  = head[AW-1:0];
  assign tidx  = tail[AW-1:0];
  assign fidx  = fill[AW-1:0];
  assign count = tail - head;
  assign full  = count[AW];

  assign eligible = cntx_pending & ~(kill_valid ? kill_mask : '0);

  always_comb begin
    grant_c   = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_CNTX; i++) begin
      cand = CW'((int'(rr) + i) % N_CNTX);
      if (!found && eligible[cand]) begin
        found          = 1'b1;
        grant_idx      = cand;
        grant_c[cand]  = 1'b1;
      end
    end
  end

  assign grant       = rstn ? grant_c : '0;
  assign mem_req     = (|grant) & ~full;
  assign mem_addr    = grant_pc;
  assign grant_taken = mem_req & mem_ack;

  assign occupied  = (count != '0);
  assign head_kill = kill_valid & (|(cntx_q[hidx] & kill_mask));
  assign out_valid = occupied & filled_q[hidx] & ~killed_q[hidx] & ~head_kill;
  // Killed heads drain on their own once their memory return has landed
  assign pop       = occupied & filled_q[hidx] & (killed_q[hidx] | head_kill | out_accept);
  assign out_instr = out_valid ? instr_q[hidx] : '0;
  assign out_pc    = out_valid ? pc_q[hidx]    : '0;
  assign out_cntx  = out_valid ? cntx_q[hidx]  : '0;

  assign awaiting = (fill != tail);
  assign fill_ok  = mem_valid & awaiting;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      rr        <= '0;
      killed_q  <= '0;
      filled_q  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (kill_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (|(cntx_q[i] & kill_mask)) killed_q[i] <= 1'b1;
        end
      end
      if (grant_taken) begin
        killed_q[tidx] <= 1'b0;
        filled_q[tidx] <= 1'b0;
        tail           <= tail + 1'b1;
        rr             <= (int'(grant_idx) == N_CNTX - 1) ? '0 : grant_idx + 1'b1;
      end
      if (fill_ok) begin
        filled_q[fidx] <= 1'b1;
        fill           <= fill + 1'b1;
      end else if (mem_valid) begin
        proto_err <= 1'b1;
      end
      if (pop) head <= head + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (grant_taken) begin
      pc_q[tidx]   <= grant_pc;
      cntx_q[tidx] <= grant;
    end
    if (fill_ok) instr_q[fidx] <= mem_data;
  end
endmodule

// File: tb/tb_fetch_sched.sv
// tb/tb_fetch_sched.sv - randomized scoreboard bench for fetch_sched against a queue-level reference model
module tb_fetch_sched;
  localparam int N = 8;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] cntx_pending, grant, kill_mask, out_cntx;
  logic [W-1:0] grant_pc, mem_addr, mem_data, out_instr, out_pc;
  logic         grant_taken, mem_req, mem_ack, mem_valid, kill_valid, out_valid, out_accept, proto_err;

  fetch_sched #(.N_CNTX(N), .LEN_WORD(W), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .cntx_pending(cntx_pending), .grant(grant), .grant_pc(grant_pc),
    .grant_taken(grant_taken), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data), .kill_valid(kill_valid), .kill_mask(kill_mask),
    .out_valid(out_valid), .out_accept(out_accept), .out_instr(out_instr), .out_pc(out_pc),
    .out_cntx(out_cntx), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pc;
    logic [N-1:0] cntx;
    logic [W-1:0] data;
    logic         killed;
    logic         filled;
  } ent_t;

  ent_t         occ[$];
  ent_t         exp_q[$];
  logic [W-1:0] pc_tab [N];
  logic [W-1:0] issue_data;
  int           rr_m = 0;
  logic         proto_m = 1'b0;
  int           checks = 0;
  int           errors = 0;
  bit           done = 1'b0;

  // The requesting context manager answers combinationally with the granted context's PC
  always_comb begin
    grant_pc = '0;
    for (int i = 0; i < N; i++) if (grant[i]) grant_pc = pc_tab[i];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int first_unfilled();
    for (int i = 0; i < occ.size(); i++) if (!occ[i].filled) return i;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] elig, egrant;
    int gi, u, c;
    logic found, ereq, etaken, hkill, eov, pop;
    ent_t e;
    u = first_unfilled();
    mem_data = (u >= 0) ? occ[u].data : $urandom;
    #1;
    elig  = cntx_pending & ~(kill_valid ? kill_mask : '0);
    found = 1'b0;
    gi    = 0;
    for (int k = 0; k < N; k++) begin
      c = (rr_m + k) % N;
      if (!found && elig[c]) begin found = 1'b1; gi = c; end
    end
    egrant = found ? N'(1 << gi) : '0;
    ereq   = found && (occ.size() < D);
    etaken = ereq && mem_ack;
    chk("grant", W'(grant), W'(egrant));
    chk("mem_req", W'(mem_req), W'(ereq));
    chk("grant_taken", W'(grant_taken), W'(etaken));
    if (ereq) chk("mem_addr", mem_addr, pc_tab[gi]);
    hkill = 1'b0;
    eov   = 1'b0;
    if (occ.size() > 0) begin
      hkill = kill_valid && |(occ[0].cntx & kill_mask);
      eov   = occ[0].filled && !occ[0].killed && !hkill;
    end
    chk("out_valid", W'(out_valid), W'(eov));
    if (eov) begin
      chk("out_pc", out_pc, occ[0].pc);
      chk("out_cntx", W'(out_cntx), W'(occ[0].cntx));
    end else begin
      chk("out_idle_zero", out_instr | out_pc | W'(out_cntx), '0);
    end
    chk("proto_err", W'(proto_err), W'(proto_m));
    pop = (occ.size() > 0) && occ[0].filled && (occ[0].killed || hkill || out_accept);
    if (kill_valid) begin
      for (int i = 0; i < occ.size(); i++)
        if (|(occ[i].cntx & kill_mask)) begin e = occ[i]; e.killed = 1'b1; occ[i] = e; end
      for (int i = 0; i < exp_q.size(); i++)
        if (|(exp_q[i].cntx & kill_mask)) begin e = exp_q[i]; e.killed = 1'b1; exp_q[i] = e; end
    end
    if (mem_valid) begin
      if (u >= 0) begin e = occ[u]; e.filled = 1'b1; occ[u] = e; end
      else proto_m = 1'b1;
    end
    if (etaken) begin
      e = '{pc: pc_tab[gi], cntx: egrant, data: issue_data, killed: 1'b0, filled: 1'b0};
      occ.push_back(e);
      exp_q.push_back(e);
      rr_m = (gi + 1) % N;
    end
    if (pop) void'(occ.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      cntx_pending = '0; mem_ack = 1'b0; kill_valid = 1'b0; out_accept = 1'b1;
      mem_valid = (first_unfilled() >= 0);
      step();
    end
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT hands over an instruction
  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      if (!done && rstn && out_valid && out_accept) begin
        while (exp_q.size() > 0 && exp_q[0].killed) void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_out", out_pc, '1);
        end else begin
          chk("mon_instr", out_instr, exp_q[0].data);
          chk("mon_pc", out_pc, exp_q[0].pc);
          chk("mon_cntx", W'(out_cntx), W'(exp_q[0].cntx));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cntx_pending = 8'hFF; mem_ack = 1'b1; mem_valid = 1'b0; kill_valid = 1'b0;
    kill_mask = '0; out_accept = 1'b0; issue_data = '0;
    for (int i = 0; i < N; i++) pc_tab[i] = 32'h1000 * (i + 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", W'(grant), '0);
      chk("rst_grant_taken", W'(grant_taken), '0);
      chk("rst_mem_req", W'(mem_req), '0);
      chk("rst_out_valid", W'(out_valid), '0);
      chk("rst_proto_err", W'(proto_err), '0);
    end
    rstn = 1'b1;
    // Consecutive round-robin grants, then fill to DEPTH and show grant while blocked
    repeat (5) begin issue_data = $urandom; step(); end
    mem_ack = 1'b0; step();
    mem_valid = 1'b1; step();
    mem_valid = 1'b0; out_accept = 1'b1; step();
    out_accept = 1'b0; mem_ack = 1'b1; issue_data = $urandom; step();
    drain(14);

    // Kill of context 0 before its return; only context 1 data reaches the output
    pc_tab[0] = 32'h100; pc_tab[1] = 32'h200; pc_tab[2] = 32'h300;
    out_accept = 1'b0; mem_valid = 1'b0; mem_ack = 1'b1;
    cntx_pending = 8'h01; issue_data = 32'hAAAA; step();
    cntx_pending = 8'h02; issue_data = 32'hBBBB; step();
    cntx_pending = 8'h00; mem_ack = 1'b0; kill_valid = 1'b1; kill_mask = 8'h01; step();
    kill_valid = 1'b0; mem_valid = 1'b1; step();
    step();
    // Head held for five cycles while later fetches keep issuing and returning
    repeat (5) begin
      chk("hold_out_valid", W'(out_valid), 32'h1);
      chk("hold_out_instr", out_instr, 32'hBBBB);
      chk("hold_out_pc", out_pc, 32'h200);
      chk("hold_out_cntx", W'(out_cntx), 32'h02);
      cntx_pending = 8'h04; mem_ack = 1'b1; out_accept = 1'b0; issue_data = $urandom;
      mem_valid = (first_unfilled() >= 0);
      step();
    end
    drain(14);

    for (int n = 0; n < 1500; n++) begin
      cntx_pending = N'($urandom);
      if ($urandom_range(0, 7) == 0) pc_tab[$urandom_range(0, N - 1)] = $urandom;
      mem_ack    = ($urandom_range(0, 9) < 7);
      mem_valid  = (first_unfilled() >= 0) && ($urandom_range(0, 1) == 1);
      kill_valid = ($urandom_range(0, 9) == 0);
      kill_mask  = N'($urandom);
      out_accept = ($urandom_range(0, 9) < 6);
      issue_data = $urandom;
      step();
    end
    drain(30);
    while (exp_q.size() > 0 && exp_q[0].killed) void'(exp_q.pop_front());
    chk("outputs_outstanding", W'(exp_q.size()), '0);

    // Return with nothing awaiting: sticky protocol error, queue untouched
    cntx_pending = '0; mem_valid = 1'b1; out_accept = 1'b0; step();
    mem_valid = 1'b0;
    repeat (3) step();
    chk("proto_err_sticky", W'(proto_err), 32'h1);

    done = 1'b1;
    @(negedge clk);
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sched.md
Name: fetch_sched

Overview:
Round-robin fetch scheduler between the per-context fetch flags kept by the context manager and the single instruction-memory read port.
- Each cycle it picks one context with a pending fetch, issues its PC to memory, and tracks the request in an in-order outstanding queue.
- Returned instructions go to the decode/inst_window path tagged with context and PC.
- On a branch hazard it discards in-flight fetches of the killed contexts.

Parameters:
N_CNTX, 8, number of contexts (one-hot width)
LEN_WORD, 32, PC / instruction width
DEPTH, 4, outstanding-queue entries (power of 2, >=2)

Ports:
clk  in  1  clock (single clock domain)
rstn  in  1  reset, asynchronous, active-low
cntx_pending  in  N_CNTX  per-context "fetch not yet issued" flags
grant  out  N_CNTX  one-hot context selected this cycle (0 if none)
grant_pc  in  LEN_WORD  next PC of the granted context, combinational from grant
grant_taken  out  1  pulse: grant issued to memory this cycle (requester clears its flag)
mem_req  out  1  memory read request
mem_addr  out  LEN_WORD  = grant_pc
mem_ack  in  1  memory accepts request this cycle
mem_valid  in  1  read data returned (in request order, >=1 cycle after accept)
mem_data  in  LEN_WORD  returned instruction
kill_valid  in  1  branch hazard this cycle
kill_mask  in  N_CNTX  contexts discarded by the hazard
out_valid  out  1  instruction available
out_accept  in  1  consumer takes instruction (i_w_accept_able)
out_instr  out  LEN_WORD  instruction
out_pc  out  LEN_WORD  its PC
out_cntx  out  N_CNTX  its context, one-hot
proto_err  out  1  sticky: mem_valid with no awaiting entry

Behaviour:
- Reset (async, rstn=0): queue empty, head/tail/fill pointers 0, rr pointer 0, proto_err 0. All outputs 0: grant, grant_taken, mem_req, out_valid, out_*.
- Eligible contexts: cntx_pending & ~(kill_valid ? kill_mask : 0).
- Arbitration: round-robin. Search starts at rr pointer, ascending with wrap N_CNTX-1 -> 0. First eligible context = grant.
- Issue condition: grant!=0 and count<DEPTH. count is the registered occupancy; a same-cycle pop does not free a slot.
- mem_req is high iff the issue condition holds; mem_addr=grant_pc.
- grant_taken = mem_req & mem_ack. On grant_taken:
  - allocate tail entry {pc, cntx, killed=0, filled=0}; tail++ (mod DEPTH)
  - rr pointer <= granted index+1 (wrap).
- No grant_taken: rr pointer unchanged; grant may change next cycle.
- mem_valid:
  - writes mem_data into the entry at the fill pointer and sets filled; fill++.
  - If fill==tail (no awaiting entry): data dropped, proto_err<=1 (sticky until reset).
- Kill: on kill_valid, every queued entry whose cntx & kill_mask !=0 gets killed<=1, filled or not. The entry still occupies its slot and still consumes its memory return.
- Output:
  - out_valid = head occupied & filled & ~killed & ~(kill_valid & |(head cntx & kill_mask)).
  - out_* driven from the head entry; 0 when out_valid=0.
- Pop:
  - head pops on (out_valid & out_accept), or automatically when the head is filled & killed (or killed this cycle); head++.
  - At most one pop per cycle.
- Latency: mem_valid in cycle t -> out_valid at the earliest in t+1 (registered data, no bypass).
- Simultaneous events:
  - Issue and pop in the same cycle: count unchanged.
  - Kill and mem_valid on the same entry: entry becomes filled and killed, then auto-pops.
- Full (count==DEPTH): mem_req=0, grant still shown, grant_taken=0.
- Empty: out_valid=0.

Test Plan:
- Reset with cntx_pending=8'hFF held -> all outputs 0 while rstn=0. After release with mem_ack=1: grants 8'h01, 8'h02, 8'h04 on consecutive cycles.
- cntx_pending=8'h81, rr pointer at 7, mem_ack=1 -> grant=8'h80, then 8'h01 (wrap).
- mem_ack=0, four issues blocked, then ack 4 without returns -> count=4, mem_req=0 with grant!=0. One mem_valid plus out_accept -> mem_req high the following cycle.
- Issue contexts 0x01 (pc 0x100) and 0x02 (pc 0x200). kill_mask=0x01 before any return. Returns 0xAAAA, 0xBBBB -> only out_instr=0xBBBB, out_pc=0x200, out_cntx=0x02 appears; 0xAAAA silently dropped.
- out_accept=0 holds the head for 5 cycles -> out_* stable. Returns keep filling later entries; no loss; order preserved after accept.
- mem_valid with empty queue -> proto_err=1 and stays 1; queue state unchanged.
